// File: rtl/lcd_freq_display_module.sv
// HD44780 8-bit driver: power-up wait, init sequence, then two-line frames
// showing a 7-digit BCD frequency and a status/page line. Optional macro
// LCD_REFRESH_ON_CHANGE_EN makes refresh change-driven instead of continuous.
module lcd_freq_display_module #(
    parameter logic [63:0] CLK_FREQ = 64'd200000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] freq_1,
    input  logic [3:0] freq_2,
    input  logic [3:0] freq_3,
    input  logic [3:0] freq_4,
    input  logic [3:0] freq_5,
    input  logic [3:0] freq_6,
    input  logic [3:0] freq_7,
    input  logic [2:0] digit_counter,
    input  logic       sel_A,
    input  logic       sel_B,
    input  logic       sel_C,
    input  logic       next_page,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       busy,
    output logic       refresh_done
);

    localparam logic [63:0] T_US_W  = ((CLK_FREQ / 64'd1000000) == 64'd0) ? 64'd1 : (CLK_FREQ / 64'd1000000);
    localparam logic [63:0] T_PWR_W = 64'd20000 * T_US_W;
    localparam logic [63:0] T_CMD_W = 64'd50 * T_US_W;
    localparam logic [63:0] T_CLR_W = 64'd2000 * T_US_W;
    localparam logic [31:0] T_US    = T_US_W[31:0];
    localparam logic [31:0] T_PWR   = T_PWR_W[31:0];
    localparam logic [31:0] T_CMD   = T_CMD_W[31:0];
    localparam logic [31:0] T_CLR   = T_CLR_W[31:0];

    localparam logic [3:0] S_PWR_WAIT    = 4'd0;
    localparam logic [3:0] S_INIT        = 4'd1;
    localparam logic [3:0] S_FRAME_START = 4'd2;
    localparam logic [3:0] S_ADDR1       = 4'd3;
    localparam logic [3:0] S_LINE1       = 4'd4;
    localparam logic [3:0] S_ADDR2       = 4'd5;
    localparam logic [3:0] S_LINE2       = 4'd6;
    localparam logic [3:0] S_FRAME_END   = 4'd7;
    localparam logic [3:0] S_IDLE        = 4'd8;

    localparam logic [1:0] PH_SETUP = 2'd0;
    localparam logic [1:0] PH_PULSE = 2'd1;
    localparam logic [1:0] PH_HOLD  = 2'd2;

    logic [3:0]  state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [33:0] snap_q, snap_d;
    logic        page_snap_q, page_snap_d;
    logic        page_q;
    logic        np_prev_q;
    logic        lcd_rs_q, lcd_rs_d;
    logic        lcd_e_q, lcd_e_d;
    logic [7:0]  lcd_data_q, lcd_data_d;
    logic        busy_q, busy_d;
    logic        refresh_done_q, refresh_done_d;
    logic [33:0] live_s;
    logic [31:0] hold_len_s;

    // Snapshot layout: {freq_7..freq_1, digit_counter, sel_A, sel_B, sel_C}
    assign live_s = {freq_7, freq_6, freq_5, freq_4, freq_3, freq_2, freq_1,
                     digit_counter, sel_A, sel_B, sel_C};

    // Clear-display needs the long hold; every other byte uses the short one.
    assign hold_len_s = (!lcd_rs_q && (lcd_data_q == 8'h01)) ? T_CLR : T_CMD;

    assign lcd_rs       = lcd_rs_q;
    assign lcd_rw       = 1'b0;
    assign lcd_e        = lcd_e_q;
    assign lcd_data     = lcd_data_q;
    assign busy         = busy_q;
    assign refresh_done = refresh_done_q;

    function automatic logic [7:0] init_cmd(input logic [3:0] idx);
        logic [7:0] c;
        case (idx)
            4'd0:    c = 8'h38;
            4'd1:    c = 8'h0C;
            4'd2:    c = 8'h01;
            4'd3:    c = 8'h06;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] digit_char(input logic [3:0] bcd, input logic [2:0] pos,
                                              input logic [2:0] dc);
        logic [7:0] c;
        if ((dc == 3'd0) && (pos == 3'd1)) begin
            c = 8'h30;
        end else if (pos <= dc) begin
            c = (bcd > 4'd9) ? 8'h3F : (8'h30 + {4'd0, bcd});
        end else begin
            c = 8'h20;
        end
        return c;
    endfunction

    function automatic logic [7:0] line1_char(input logic [3:0] idx, input logic [33:0] snap);
        logic [7:0] c;
        case (idx)
            4'd0:    c = digit_char(snap[33:30], 3'd7, snap[5:3]);
            4'd1:    c = digit_char(snap[29:26], 3'd6, snap[5:3]);
            4'd2:    c = digit_char(snap[25:22], 3'd5, snap[5:3]);
            4'd3:    c = digit_char(snap[21:18], 3'd4, snap[5:3]);
            4'd4:    c = digit_char(snap[17:14], 3'd3, snap[5:3]);
            4'd5:    c = digit_char(snap[13:10], 3'd2, snap[5:3]);
            4'd6:    c = digit_char(snap[9:6],   3'd1, snap[5:3]);
            4'd8:    c = 8'h48;
            4'd9:    c = 8'h7A;
            default: c = 8'h20;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] line2_char(input logic [3:0] idx, input logic [33:0] snap,
                                              input logic page);
        logic [7:0] c;
        if (page) begin
            case (idx)
                4'd0:    c = 8'h44;
                4'd1:    c = 8'h49;
                4'd2:    c = 8'h47;
                4'd3:    c = 8'h49;
                4'd4:    c = 8'h54;
                4'd5:    c = 8'h53;
                4'd6:    c = 8'h3A;
                4'd7:    c = 8'h30 + {5'd0, snap[5:3]};
                default: c = 8'h20;
            endcase
        end else begin
            case (idx)
                4'd0:    c = 8'h41;
                4'd1:    c = 8'h3A;
                4'd2:    c = snap[2] ? 8'h31 : 8'h30;
                4'd4:    c = 8'h42;
                4'd5:    c = 8'h3A;
                4'd6:    c = snap[1] ? 8'h31 : 8'h30;
                4'd8:    c = 8'h43;
                4'd9:    c = 8'h3A;
                4'd10:   c = snap[0] ? 8'h31 : 8'h30;
                default: c = 8'h20;
            endcase
        end
        return c;
    endfunction

    // Page toggles on any next_page rising edge, independent of the frame FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            np_prev_q <= 1'b0;
            page_q    <= 1'b0;
        end else begin
            np_prev_q <= next_page;
            if (next_page && !np_prev_q) begin
                page_q <= ~page_q;
            end else begin
                page_q <= page_q;
            end
        end
    end

    // Sequencer: each byte runs SETUP -> PULSE -> HOLD; HOLD end picks the next byte or state.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        page_snap_d = page_snap_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_data_d  = lcd_data_q;
        lcd_e_d     = 1'b0;
        case (state_q)
            S_PWR_WAIT: begin
                if (cnt_q == (T_PWR - 32'd1)) begin
                    state_d    = S_INIT;
                    idx_d      = 4'd0;
                    phase_d    = PH_SETUP;
                    cnt_d      = 32'd0;
                    lcd_rs_d   = 1'b0;
                    lcd_data_d = init_cmd(4'd0);
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_INIT, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2: begin
                case (phase_q)
                    PH_SETUP: begin
                        phase_d = PH_PULSE;
                        cnt_d   = 32'd0;
                        lcd_e_d = 1'b1;
                    end
                    PH_PULSE: begin
                        if (cnt_q == (T_US - 32'd1)) begin
                            phase_d = PH_HOLD;
                            cnt_d   = 32'd0;
                        end else begin
                            cnt_d   = cnt_q + 32'd1;
                            lcd_e_d = 1'b1;
                        end
                    end
                    PH_HOLD: begin
                        if (cnt_q == (hold_len_s - 32'd1)) begin
                            phase_d = PH_SETUP;
                            cnt_d   = 32'd0;
                            case (state_q)
                                S_INIT: begin
                                    if (idx_q < 4'd3) begin
                                        idx_d      = idx_q + 4'd1;
                                        lcd_data_d = init_cmd(idx_q + 4'd1);
                                    end else begin
                                        state_d = S_FRAME_START;
                                    end
                                end
                                S_ADDR1: begin
                                    state_d    = S_LINE1;
                                    idx_d      = 4'd0;
                                    lcd_rs_d   = 1'b1;
                                    lcd_data_d = line1_char(4'd0, snap_q);
                                end
                                S_LINE1: begin
                                    if (idx_q < 4'd9) begin
                                        idx_d      = idx_q + 4'd1;
                                        lcd_data_d = line1_char(idx_q + 4'd1, snap_q);
                                    end else begin
                                        state_d    = S_ADDR2;
                                        lcd_rs_d   = 1'b0;
                                        lcd_data_d = 8'hC0;
                                    end
                                end
                                S_ADDR2: begin
                                    state_d    = S_LINE2;
                                    idx_d      = 4'd0;
                                    lcd_rs_d   = 1'b1;
                                    lcd_data_d = line2_char(4'd0, snap_q, page_snap_q);
                                end
                                S_LINE2: begin
                                    if (idx_q < 4'd10) begin
                                        idx_d      = idx_q + 4'd1;
                                        lcd_data_d = line2_char(idx_q + 4'd1, snap_q, page_snap_q);
                                    end else begin
                                        state_d = S_FRAME_END;
                                    end
                                end
                                default: begin
                                    state_d = S_PWR_WAIT;
                                end
                            endcase
                        end else begin
                            cnt_d = cnt_q + 32'd1;
                        end
                    end
                    default: begin
                        phase_d = PH_SETUP;
                        cnt_d   = 32'd0;
                    end
                endcase
            end
            S_FRAME_START: begin
                snap_d      = live_s;
                page_snap_d = page_q;
                state_d     = S_ADDR1;
                phase_d     = PH_SETUP;
                cnt_d       = 32'd0;
                lcd_rs_d    = 1'b0;
                lcd_data_d  = 8'h80;
            end
            S_FRAME_END: begin
`ifdef LCD_REFRESH_ON_CHANGE_EN
                state_d = S_IDLE;
`else
                state_d = S_FRAME_START;
`endif
            end
            S_IDLE: begin
                if ((live_s != snap_q) || (page_q != page_snap_q)) begin
                    state_d = S_FRAME_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_PWR_WAIT;
                cnt_d   = 32'd0;
            end
        endcase
        busy_d         = (state_d != S_IDLE);
        refresh_done_d = (state_d == S_FRAME_END);
    end

    // State, snapshot and registered LCD outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_PWR_WAIT;
            phase_q        <= PH_SETUP;
            cnt_q          <= 32'd0;
            idx_q          <= 4'd0;
            snap_q         <= 34'd0;
            page_snap_q    <= 1'b0;
            lcd_rs_q       <= 1'b0;
            lcd_e_q        <= 1'b0;
            lcd_data_q     <= 8'h00;
            busy_q         <= 1'b1;
            refresh_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            snap_q         <= snap_d;
            page_snap_q    <= page_snap_d;
            lcd_rs_q       <= lcd_rs_d;
            lcd_e_q        <= lcd_e_d;
            lcd_data_q     <= lcd_data_d;
            busy_q         <= busy_d;
            refresh_done_q <= refresh_done_d;
        end
    end

endmodule
